// File: rtl/seg_display_ctrl_if.sv
// seg_display_ctrl_if: load request and scanned 7-segment outputs of seg_display_ctrl
interface seg_display_ctrl_if #(
    parameter int NUM_DIGITS = 8,
    parameter int DATA_W     = 32
);
    logic                  load;
    logic [DATA_W-1:0]     data;
    logic                  dec_mode;
    logic                  blank_lz;
    logic [NUM_DIGITS-1:0] dp_mask;
    logic [NUM_DIGITS-1:0] blink_mask;
    logic                  busy;
    logic                  ovf;
    logic [NUM_DIGITS-1:0] digit_en;
    logic [7:0]            sseg0;
    logic [7:0]            sseg1;
    modport master (
        output load, data, dec_mode, blank_lz, dp_mask, blink_mask,
        input  busy, ovf, digit_en, sseg0, sseg1
    );
    modport slave (
        input  load, data, dec_mode, blank_lz, dp_mask, blink_mask,
        output busy, ovf, digit_en, sseg0, sseg1
    );
endinterface

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: multiplexed 7-segment scanner showing a hex or decimal value;
// decimal values are converted serially by double-dabble, one bit per cycle.
module seg_display_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int DATA_W      = 32,
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_TICKS = 256
) (
    input logic clk,
    input logic rst,
    seg_display_ctrl_if.slave bus
);
    localparam int W  = 4 * NUM_DIGITS;
    localparam int SW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(SCAN_DIV);
    localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
    localparam int KW = $clog2(DATA_W);

    logic [W-1:0]          disp, bcd, bcd_adj, bcd_next;
    logic [DATA_W-1:0]     sh;
    logic [KW-1:0]         step;
    logic [CW-1:0]         cnt;
    logic [SW-1:0]         sel;
    logic [BW-1:0]         bcnt;
    logic [NUM_DIGITS-1:0] digit_en;
    logic [7:0]            sseg0, sseg1, pat;
    logic [6:0]            glyph;
    logic [3:0]            nib;
    logic                  disp_dec, busy, ovf, ovf_acc, carry, phase, tick, blank, hi;

    assign bus.busy     = busy;
    assign bus.ovf      = ovf;
    assign bus.digit_en = digit_en;
    assign bus.sseg0    = sseg0;
    assign bus.sseg1    = sseg1;

    // add-3 on every BCD digit >= 5, then shift the next binary bit in
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        {carry, bcd_next} = {bcd_adj, sh[DATA_W-1]};
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            busy     <= 1'b0;
            ovf      <= 1'b0;
            ovf_acc  <= 1'b0;
            disp     <= '0;
            disp_dec <= 1'b0;
            bcd      <= '0;
            sh       <= '0;
            step     <= '0;
        end else if (busy) begin
            bcd     <= bcd_next;
            sh      <= sh << 1;
            step    <= step + 1'b1;
            ovf_acc <= ovf_acc | carry;
            if (step == KW'(DATA_W - 1)) begin
                busy     <= 1'b0;
                disp     <= bcd_next;
                disp_dec <= 1'b1;
                ovf      <= ovf_acc | carry;
            end
        end else if (bus.load) begin
            if (bus.dec_mode) begin
                busy    <= 1'b1;
                sh      <= bus.data;
                bcd     <= '0;
                step    <= '0;
                ovf_acc <= 1'b0;
            end else begin
                disp     <= W'(bus.data);
                disp_dec <= 1'b0;
                ovf      <= 1'b0;
            end
        end

    assign tick = cnt == CW'(SCAN_DIV - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt   <= '0;
            sel   <= '0;
            bcnt  <= '0;
            phase <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                sel   <= sel == SW'(NUM_DIGITS - 1) ? '0 : sel + 1'b1;
                bcnt  <= bcnt == BW'(BLINK_TICKS - 1) ? '0 : bcnt + 1'b1;
                phase <= bcnt == BW'(BLINK_TICKS - 1) ? ~phase : phase;
            end
        end

    always_comb begin
        nib = disp[4*sel +: 4];
        case (nib)
            4'h0: glyph = 7'b1111110;
            4'h1: glyph = 7'b0110000;
            4'h2: glyph = 7'b1101101;
            4'h3: glyph = 7'b1111001;
            4'h4: glyph = 7'b0110011;
            4'h5: glyph = 7'b1011011;
            4'h6: glyph = 7'b1011111;
            4'h7: glyph = 7'b1110000;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1111011;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b0011111;
            4'hC: glyph = 7'b1001110;
            4'hD: glyph = 7'b0111101;
            4'hE: glyph = 7'b1001111;
            default: glyph = 7'b1000111;
        endcase
        // a digit is a leading zero when it and every digit above it are zero
        blank = disp_dec && bus.blank_lz && sel != '0 && (disp >> (4*sel)) == '0;
        pat   = (phase && bus.blink_mask[sel]) ? 8'h00 : {blank ? 7'h00 : glyph, bus.dp_mask[sel]};
        hi    = int'(sel) >= 4;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            digit_en <= '0;
            sseg0    <= 8'h00;
            sseg1    <= 8'h00;
        end else begin
            digit_en <= NUM_DIGITS'(1) << sel;
            sseg0    <= hi ? 8'h00 : pat;
            sseg1    <= hi ? pat : 8'h00;
        end
endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: directed plus randomized checks of seg_display_ctrl against
// a digit-level model (value -> digits by arithmetic, scan position from cycle count).
module tb_seg_display_ctrl;
    localparam int ND = 8, DW = 32, SD = 4, BT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0, miscompares = 0, n = 0;

    logic [3:0]    m_dig [ND];
    bit            m_dec, m_blz, m_ovf;
    logic [ND-1:0] m_dp, m_blink;
    logic [6:0]    glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    seg_display_ctrl_if #(.NUM_DIGITS(ND), .DATA_W(DW)) bus ();

    seg_display_ctrl #(.NUM_DIGITS(ND), .DATA_W(DW), .SCAN_DIV(SD), .BLINK_TICKS(BT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_pat(int d, bit ph);
        logic [6:0] g;
        bit lead;
        g = glyph[m_dig[d]];
        lead = 1'b1;
        for (int j = d; j < ND; j++) if (m_dig[j] != 4'd0) lead = 1'b0;
        if (m_dec && m_blz && d != 0 && lead) g = 7'h00;
        return (ph && m_blink[d]) ? 8'h00 : {g, m_dp[d]};
    endfunction

    // outputs after edge n were computed from state holding floor((n-1)/SD) ticks
    task automatic step(bit busy_exp);
        int t, d;
        bit ph;
        logic [7:0] p;
        @(posedge clk);
        n++;
        #1;
        t  = (n - 1) / SD;
        d  = t % ND;
        ph = ((t / BT) % 2) == 1;
        p  = exp_pat(d, ph);
        cmp("digit_en", 32'(bus.digit_en), 32'(1 << d));
        cmp("sseg0", 32'(bus.sseg0), d < 4 ? 32'(p) : 32'h0);
        cmp("sseg1", 32'(bus.sseg1), d >= 4 ? 32'(p) : 32'h0);
        cmp("busy", 32'(bus.busy), 32'(busy_exp));
        cmp("ovf", 32'(bus.ovf), 32'(m_ovf));
    endtask

    task automatic set_hex(logic [31:0] v);
        m_dec = 1'b0;
        for (int i = 0; i < ND; i++) m_dig[i] = v[4*i +: 4];
    endtask

    task automatic set_dec(logic [31:0] v);
        longint unsigned p;
        p = 1;
        m_dec = 1'b1;
        for (int i = 0; i < ND; i++) begin
            m_dig[i] = 4'((longint'(v) / p) % 10);
            p = p * 10;
        end
    endtask

    task automatic do_load(logic [31:0] v, bit dec, bit inject);
        bus.data = v;
        bus.dec_mode = dec;
        bus.load = 1'b1;
        if (!dec) begin
            m_ovf = 1'b0;
            step(1'b0);
            bus.load = 1'b0;
            set_hex(v);
        end else begin
            step(1'b1);
            bus.load = 1'b0;
            for (int k = 1; k < DW; k++) begin
                if (inject && k == 5) begin
                    bus.data = 32'h5;
                    bus.dec_mode = 1'b0;
                    bus.load = 1'b1;
                end
                step(1'b1);
                bus.load = 1'b0;
            end
            m_ovf = longint'(v) > 99999999;
            step(1'b0);
            set_dec(v);
        end
    endtask

    task automatic model_reset();
        n = 0;
        m_ovf = 1'b0;
        set_hex(32'h0);
    endtask

    initial begin
        bus.load = 1'b0;
        bus.data = '0;
        bus.dec_mode = 1'b0;
        bus.blank_lz = 1'b0;
        bus.dp_mask = '0;
        bus.blink_mask = '0;
        m_blz = 1'b0;
        m_dp = '0;
        m_blink = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_busy", 32'(bus.busy), 32'h0);
        cmp("rst_ovf", 32'(bus.ovf), 32'h0);
        cmp("rst_digit_en", 32'(bus.digit_en), 32'h0);
        cmp("rst_sseg0", 32'(bus.sseg0), 32'h0);
        cmp("rst_sseg1", 32'(bus.sseg1), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0);
        cmp("first_sseg0", 32'(bus.sseg0), 32'hFC);
        repeat (36) step(1'b0);

        do_load(32'h0000_00AB, 1'b0, 1'b0);
        repeat (34) step(1'b0);

        bus.blank_lz = 1'b1;
        m_blz = 1'b1;
        do_load(32'd1234, 1'b1, 1'b0);
        repeat (34) step(1'b0);

        do_load(32'hFFFF_FFFF, 1'b1, 1'b1);
        repeat (34) step(1'b0);

        bus.blink_mask = 8'h01;
        m_blink = 8'h01;
        bus.dp_mask = 8'h02;
        m_dp = 8'h02;
        repeat (40) step(1'b0);

        repeat (10) begin
            logic [31:0] v;
            bit dec;
            v = $urandom_range(0, 1) == 1 ? $urandom : $urandom_range(0, 99999);
            dec = $urandom_range(0, 1) == 1;
            m_blz = $urandom_range(0, 1) == 1;
            bus.blank_lz = m_blz;
            m_dp = ND'($urandom);
            bus.dp_mask = m_dp;
            m_blink = ND'($urandom);
            bus.blink_mask = m_blink;
            do_load(v, dec, 1'b0);
            repeat (20) step(1'b0);
        end

        bus.dp_mask = '0;
        m_dp = '0;
        bus.blink_mask = '0;
        m_blink = '0;
        bus.data = 32'd987654;
        bus.dec_mode = 1'b1;
        bus.load = 1'b1;
        step(1'b1);
        bus.load = 1'b0;
        repeat (9) step(1'b1);
        #2;
        rst = 1'b1;
        #1;
        cmp("abort_busy", 32'(bus.busy), 32'h0);
        cmp("abort_ovf", 32'(bus.ovf), 32'h0);
        cmp("abort_digit_en", 32'(bus.digit_en), 32'h0);
        cmp("abort_sseg0", 32'(bus.sseg0), 32'h0);
        cmp("abort_sseg1", 32'(bus.sseg1), 32'h0);
        @(posedge clk);
        #1;
        cmp("abort_hold_digit_en", 32'(bus.digit_en), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (40) step(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
